fitness_eval: RTL and testbench
===============================

// Module: fitness_eval
// PURPOSE
//  Pipelined lattice-energy fitness evaluator for the EC engine. Holds a per-type self-energy
//  vector and a pairwise interaction matrix; for each individual (chain of LATTICE_LENGTH
//  particles) outputs E = sum_j self[p_j] + 2*sum_{j>0} inter[p_{j-1}][p_j].
//  Accepts one individual per cycle; a population of POP_SIZE ends with a done pulse.
// PARAMETERS
//  NUM_PARTICLE_TYPE        3    number of particle types
//  DATA_WIDTH               4    width of one energy coefficient (unsigned)
//  PARTICLE_LENGTH          2    bits per particle code
//  LATTICE_LENGTH           11   particles per individual
//  SELF_FIT_LENGTH          10   output energy width
//  SELF_ENERGY_VEC_LENGTH   NUM_PARTICLE_TYPE*DATA_WIDTH
//  INTERATION_MATRIX_LENGTH NUM_PARTICLE_TYPE**2*DATA_WIDTH
//  INDIVIDUAL_LENGTH        LATTICE_LENGTH*PARTICLE_LENGTH
//  POP_SIZE                 50   individuals per population
// PORTS
//  clk_i              in   1    single clock, rising edge
//  rst_n              in   1    reset, asynchronous, active-HIGH (codebase name kept)
//  self_energy_vec_i  in   SELF_ENERGY_VEC_LENGTH    self[0] in MSBs ... self[N-1] in LSBs
//  interact_matrix_i  in   INTERATION_MATRIX_LENGTH  row-major, inter[0][0] in MSBs
//  individual_vec_i   in   INDIVIDUAL_LENGTH  particle j at [PARTICLE_LENGTH*j +: PARTICLE_LENGTH]
//  in_valid_i         in   1    individual_vec_i/ind_idx_i valid this cycle
//  Set_data_i         in   1    request coefficient (re)load
//  ind_idx_i          in   1    individual tag, carried to ind_wb_idx_ff_o
//  out_valid_ff_o     out  1    total_energy_ff_o valid
//  done_ff_o          out  1    one-cycle pulse with the POP_SIZE-th result
//  total_energy_ff_o  out  SELF_FIT_LENGTH  energy of the individual
//  ind_wb_idx_ff_o    out  1    tag of the individual
// BEHAVIOUR
//  - Reset: all outputs 0, coefficient registers 0, pipeline valids 0, counter 0, state IDLE.
//  - FSM: IDLE -Set_data_i-> LOAD; LOAD: on first edge with Set_data_i=0 capture both coefficient
//    buses, go RUN; RUN: accept in_valid_i beats; after POP_SIZE results -> IDLE.
//    Set_data_i in RUN/IDLE -> LOAD (pipeline flushed, counter cleared).
//  - in_valid_i ignored outside RUN. Particle codes >= NUM_PARTICLE_TYPE contribute 0.
//  - Pipeline, 3 stages, latency 3: beat sampled at edge t gives outputs after edge t+3.
//    S1: register looked-up self terms and LATTICE_LENGTH-1 pair terms; S2: self sum and pair sum;
//    S3: total = self_sum + (pair_sum<<1), truncated modulo 2^SELF_FIT_LENGTH.
//  - Throughput one per cycle; bubbles propagate (out_valid_ff_o=0, energy/idx hold last value).
//  - Result counter counts out_valid beats; done_ff_o=1 with beat POP_SIZE, counter wraps to 0.
//  - Reset mid-operation discards all in-flight beats immediately.
// CONFIGURATION
//  FITNESS_SAT_EN defined: S3 saturates to 2^SELF_FIT_LENGTH-1 on overflow; undefined: wraps.
// STRUCTURE
//  Package fitness_pkg: state enum {IDLE,LOAD,RUN}, width localparams, coefficient unpack fns.
//  Sub-module pair_energy_lut: combinational inter[a][b] lookup, one instance per adjacent pair.
// TESTING
//  - self={1,2,3}, inter rows {A,4,1},{4,A,5},{1,5,A}; all-type-0 individual -> 11*1+2*10*10=211.
//  - all-type-2 -> 11*3+2*10*10=233 after exactly 3 cycles, out_valid_ff_o=1.
//  - 50 back-to-back random individuals -> each matches model at latency 3, done_ff_o on #50 only.
//  - in_valid_i gap of 2 cycles mid-stream -> 2-cycle out_valid bubble, results in order, tags kept.
//  - Set_data_i then new coefficients -> subsequent results use new values; in_valid in IDLE ignored.
//  - Assert reset with 3 beats in flight -> all outputs 0 next cycle, no stale result afterwards.

Source files
------------

// File: rtl/fitness_eval_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fitness_pkg                                                  |
// | Description : Shared widths, FSM state type and coefficient unpack helpers |
// |               for the lattice-energy fitness evaluator.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fitness_pkg;

    localparam int NUM_PARTICLE_TYPE        = 3;
    localparam int DATA_WIDTH               = 4;
    localparam int PARTICLE_LENGTH          = 2;
    localparam int LATTICE_LENGTH           = 11;
    localparam int SELF_FIT_LENGTH          = 10;
    localparam int SELF_ENERGY_VEC_LENGTH   = NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int INTERATION_MATRIX_LENGTH = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int INDIVIDUAL_LENGTH        = LATTICE_LENGTH * PARTICLE_LENGTH;
    localparam int POP_SIZE                 = 50;

    // Sum widths are sized so the stage-2 adders can never overflow.
    localparam int SELF_SUM_W = DATA_WIDTH + $clog2(LATTICE_LENGTH);
    localparam int PAIR_SUM_W = DATA_WIDTH + $clog2(LATTICE_LENGTH - 1);
    localparam int RES_CNT_W  = $clog2(POP_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    // self[code]; self[0] sits in the MSBs. Codes with no matching type give 0.
    function automatic logic [DATA_WIDTH-1:0] self_coef(
        input logic [SELF_ENERGY_VEC_LENGTH-1:0] vec,
        input logic [PARTICLE_LENGTH-1:0]        code
    );
        logic [DATA_WIDTH-1:0] res;
        res = '0;
        for (int t = 0; t < NUM_PARTICLE_TYPE; t++) begin
            if (code == PARTICLE_LENGTH'(t)) begin
                res = vec[(NUM_PARTICLE_TYPE-1-t)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    // inter[a][b], row-major with inter[0][0] in the MSBs. Any invalid code gives 0.
    function automatic logic [DATA_WIDTH-1:0] inter_coef(
        input logic [INTERATION_MATRIX_LENGTH-1:0] mat,
        input logic [PARTICLE_LENGTH-1:0]          code_a,
        input logic [PARTICLE_LENGTH-1:0]          code_b
    );
        logic [DATA_WIDTH-1:0] res;
        res = '0;
        for (int a = 0; a < NUM_PARTICLE_TYPE; a++) begin
            for (int b = 0; b < NUM_PARTICLE_TYPE; b++) begin
                if ((code_a == PARTICLE_LENGTH'(a)) && (code_b == PARTICLE_LENGTH'(b))) begin
                    res = mat[(NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE-1-(a*NUM_PARTICLE_TYPE+b))*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fitness_eval_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : fitness_eval_if                                              |
// | Description : Coefficient, individual and result bundle of fitness_eval.  |
// |               master = stimulus side, slave = evaluator side.             |
// | Ports       : self_energy_vec_i, interact_matrix_i, individual_vec_i,      |
// |               in_valid_i, Set_data_i, ind_idx_i (master -> slave);         |
// |               out_valid_ff_o, done_ff_o, total_energy_ff_o,                |
// |               ind_wb_idx_ff_o (slave -> master)                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fitness_eval_if;
    import fitness_pkg::*;

    logic [SELF_ENERGY_VEC_LENGTH-1:0]   self_energy_vec_i;
    logic [INTERATION_MATRIX_LENGTH-1:0] interact_matrix_i;
    logic [INDIVIDUAL_LENGTH-1:0]        individual_vec_i;
    logic                                in_valid_i;
    logic                                Set_data_i;
    logic                                ind_idx_i;
    logic                                out_valid_ff_o;
    logic                                done_ff_o;
    logic [SELF_FIT_LENGTH-1:0]          total_energy_ff_o;
    logic                                ind_wb_idx_ff_o;

    modport master (
        output self_energy_vec_i, interact_matrix_i, individual_vec_i,
               in_valid_i, Set_data_i, ind_idx_i,
        input  out_valid_ff_o, done_ff_o, total_energy_ff_o, ind_wb_idx_ff_o
    );

    modport slave (
        input  self_energy_vec_i, interact_matrix_i, individual_vec_i,
               in_valid_i, Set_data_i, ind_idx_i,
        output out_valid_ff_o, done_ff_o, total_energy_ff_o, ind_wb_idx_ff_o
    );

endinterface
`default_nettype wire

// File: rtl/fitness_eval_pair_energy_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pair_energy_lut                                              |
// | Description : Combinational interaction lookup inter[a][b] for one pair   |
// |               of adjacent particles.                                       |
// | Ports       : i_matrix  - packed interaction matrix                        |
// |               i_code_a  - left particle code                               |
// |               i_code_b  - right particle code                              |
// |               o_energy  - interaction coefficient (0 for invalid codes)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pair_energy_lut
    import fitness_pkg::*;
(
    input  logic [INTERATION_MATRIX_LENGTH-1:0] i_matrix,
    input  logic [PARTICLE_LENGTH-1:0]          i_code_a,
    input  logic [PARTICLE_LENGTH-1:0]          i_code_b,
    output logic [DATA_WIDTH-1:0]               o_energy
);

    assign o_energy = inter_coef(i_matrix, i_code_a, i_code_b);

endmodule
`default_nettype wire

// File: rtl/fitness_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fitness_eval                                                 |
// | Description : Pipelined lattice-energy fitness evaluator.                 |
// |               E = sum self[p_j] + 2 * sum inter[p_(j-1)][p_j]              |
// |               One individual per cycle, result 3 edges after the sampling  |
// |               edge, done pulse with every POP_SIZE-th result.              |
// | Ports       : clk_i  - clock, rising edge                                  |
// |               rst_n  - asynchronous reset, active HIGH                     |
// |               bus    - fitness_eval_if.slave (coefficients, individual,    |
// |                        handshake and result signals)                       |
// | Config      : FITNESS_SAT_EN - saturate the energy instead of wrapping     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fitness_eval
    import fitness_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_n,
    fitness_eval_if.slave bus
);

    state_e                              r_state;
    logic [SELF_ENERGY_VEC_LENGTH-1:0]   r_self_vec;
    logic [INTERATION_MATRIX_LENGTH-1:0] r_inter_mat;
    logic [RES_CNT_W-1:0]                r_res_cnt;

    // Beat capture register: the sampling edge.
    logic                                r_s0_valid;
    logic [INDIVIDUAL_LENGTH-1:0]        r_s0_ind;
    logic                                r_s0_idx;

    // S1: looked-up terms.
    logic                                         r_s1_valid;
    logic [LATTICE_LENGTH-1:0][DATA_WIDTH-1:0]    r_s1_self;
    logic [LATTICE_LENGTH-2:0][DATA_WIDTH-1:0]    r_s1_pair;
    logic                                         r_s1_idx;

    // S2: partial sums.
    logic                                r_s2_valid;
    logic [SELF_SUM_W-1:0]               r_s2_self_sum;
    logic [PAIR_SUM_W-1:0]               r_s2_pair_sum;
    logic                                r_s2_idx;

    // S3: registered outputs.
    logic                                r_out_valid;
    logic                                r_done;
    logic [SELF_FIT_LENGTH-1:0]          r_energy;
    logic                                r_out_idx;

    logic [LATTICE_LENGTH-1:0][DATA_WIDTH-1:0] w_self_terms;
    logic [LATTICE_LENGTH-2:0][DATA_WIDTH-1:0] w_pair_terms;
    logic [SELF_SUM_W-1:0]               w_self_sum;
    logic [PAIR_SUM_W-1:0]               w_pair_sum;
    logic [SELF_FIT_LENGTH-1:0]          w_total;
    logic                                w_flush;
    logic                                w_accept;

    // A reload request outside LOAD discards everything in flight; a beat
    // presented in the same cycle as the request is discarded with it.
    assign w_flush  = bus.Set_data_i && (r_state != LOAD);
    assign w_accept = bus.in_valid_i && (r_state == RUN) && !bus.Set_data_i;

    // ---------------- lookups (from the captured beat) ----------------
    always_comb begin
        w_self_terms = '0;
        for (int i = 0; i < LATTICE_LENGTH; i++) begin
            w_self_terms[i] = self_coef(r_self_vec, r_s0_ind[PARTICLE_LENGTH*i +: PARTICLE_LENGTH]);
        end
    end

    for (genvar j = 1; j < LATTICE_LENGTH; j++) begin : g_pair
        pair_energy_lut u_lut (
            .i_matrix (r_inter_mat),
            .i_code_a (r_s0_ind[PARTICLE_LENGTH*(j-1) +: PARTICLE_LENGTH]),
            .i_code_b (r_s0_ind[PARTICLE_LENGTH*j +: PARTICLE_LENGTH]),
            .o_energy (w_pair_terms[j-1])
        );
    end

    // ---------------- sums ----------------
    always_comb begin
        w_self_sum = '0;
        w_pair_sum = '0;
        for (int i = 0; i < LATTICE_LENGTH; i++) begin
            w_self_sum = w_self_sum + SELF_SUM_W'(r_s1_self[i]);
        end
        for (int i = 0; i < LATTICE_LENGTH - 1; i++) begin
            w_pair_sum = w_pair_sum + PAIR_SUM_W'(r_s1_pair[i]);
        end
    end

    // ---------------- final combine ----------------
`ifdef FITNESS_SAT_EN
    localparam int c_FULL_W = ((SELF_SUM_W > PAIR_SUM_W + 1) ? SELF_SUM_W : PAIR_SUM_W + 1) + 1;
    // Always at least one bit wider than the output so overflow is observable.
    localparam int c_CALC_W = (c_FULL_W > SELF_FIT_LENGTH) ? c_FULL_W : SELF_FIT_LENGTH + 1;
    logic [c_CALC_W-1:0] w_total_full;
    assign w_total_full = c_CALC_W'(r_s2_self_sum) + (c_CALC_W'(r_s2_pair_sum) << 1);
    assign w_total = (|w_total_full[c_CALC_W-1:SELF_FIT_LENGTH]) ?
                     {SELF_FIT_LENGTH{1'b1}} : w_total_full[SELF_FIT_LENGTH-1:0];
`else
    assign w_total = SELF_FIT_LENGTH'(r_s2_self_sum) + (SELF_FIT_LENGTH'(r_s2_pair_sum) << 1);
`endif

    // ---------------- datapath stages ----------------
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            r_s0_valid    <= 1'b0;
            r_s0_ind      <= '0;
            r_s0_idx      <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_self     <= '0;
            r_s1_pair     <= '0;
            r_s1_idx      <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s2_self_sum <= '0;
            r_s2_pair_sum <= '0;
            r_s2_idx      <= 1'b0;
        end else if (w_flush) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_ind <= bus.individual_vec_i;
                r_s0_idx <= bus.ind_idx_i;
            end
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_self <= w_self_terms;
                r_s1_pair <= w_pair_terms;
                r_s1_idx  <= r_s0_idx;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_self_sum <= w_self_sum;
                r_s2_pair_sum <= w_pair_sum;
                r_s2_idx      <= r_s1_idx;
            end
        end
    end

    // ---------------- control FSM, result counter, output stage ----------------
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_self_vec  <= '0;
            r_inter_mat <= '0;
            r_res_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_energy    <= '0;
            r_out_idx   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            if (w_flush) begin
                r_state   <= LOAD;
                r_res_cnt <= '0;
            end else begin
                if (r_s2_valid) begin
                    r_out_valid <= 1'b1;
                    r_energy    <= w_total;
                    r_out_idx   <= r_s2_idx;
                    if (r_res_cnt == RES_CNT_W'(POP_SIZE - 1)) begin
                        r_done    <= 1'b1;
                        r_res_cnt <= '0;
                        if (r_state == RUN) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_res_cnt <= r_res_cnt + 1'b1;
                    end
                end
                // Coefficients are captured once the reload request is released.
                if ((r_state == LOAD) && !bus.Set_data_i) begin
                    r_self_vec  <= bus.self_energy_vec_i;
                    r_inter_mat <= bus.interact_matrix_i;
                    r_state     <= RUN;
                end
            end
        end
    end

    assign bus.out_valid_ff_o    = r_out_valid;
    assign bus.done_ff_o         = r_done;
    assign bus.total_energy_ff_o = r_energy;
    assign bus.ind_wb_idx_ff_o   = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_fitness_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fitness_eval                                              |
// | Description : Scoreboard bench for fitness_eval: stimulus pushes model     |
// |               results with their due cycle, a negedge monitor pops and     |
// |               compares whenever the evaluator presents a result.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fitness_eval;
    import fitness_pkg::*;

    typedef struct {
        int   energy;
        logic idx;
        logic done;
        int   due;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   res_num = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    int self_m [NUM_PARTICLE_TYPE];
    int inter_m[NUM_PARTICLE_TYPE][NUM_PARTICLE_TYPE];

    fitness_eval_if bus_if();

    fitness_eval dut (
        .clk_i (clk),
        .rst_n (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Energy straight from the definition, on the loaded coefficient tables.
    function automatic int model_energy(input logic [INDIVIDUAL_LENGTH-1:0] ind);
        int p[LATTICE_LENGTH];
        int e;
        e = 0;
        for (int j = 0; j < LATTICE_LENGTH; j++) p[j] = int'(ind[PARTICLE_LENGTH*j +: PARTICLE_LENGTH]);
        for (int j = 0; j < LATTICE_LENGTH; j++)
            if (p[j] < NUM_PARTICLE_TYPE) e += self_m[p[j]];
        for (int j = 1; j < LATTICE_LENGTH; j++)
            if (p[j-1] < NUM_PARTICLE_TYPE && p[j] < NUM_PARTICLE_TYPE) e += 2 * inter_m[p[j-1]][p[j]];
`ifdef FITNESS_SAT_EN
        if (e > (1 << SELF_FIT_LENGTH) - 1) e = (1 << SELF_FIT_LENGTH) - 1;
`else
        e = e % (1 << SELF_FIT_LENGTH);
`endif
        return e;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.out_valid_ff_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", int'(bus_if.out_valid_ff_o), 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("energy",  int'(bus_if.total_energy_ff_o), mon_e.energy);
                    check("tag",     int'(bus_if.ind_wb_idx_ff_o), int'(mon_e.idx));
                    check("done",    int'(bus_if.done_ff_o), int'(mon_e.done));
                    check("latency", cyc, mon_e.due);
                end
            end else begin
                if (bus_if.done_ff_o) check("done_without_valid", int'(bus_if.done_ff_o), 0);
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    check("missing_result", int'(bus_if.out_valid_ff_o), 1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [INDIVIDUAL_LENGTH-1:0] ind, input logic tag, input bit accepted);
        exp_t e;
        bus_if.individual_vec_i = ind;
        bus_if.ind_idx_i        = tag;
        bus_if.in_valid_i       = 1'b1;
        if (accepted) begin
            res_num++;
            e.energy = model_energy(ind);
            e.idx    = tag;
            e.done   = (res_num == POP_SIZE);
            if (e.done) res_num = 0;
            e.due    = cyc + 4;
            sb_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle_cycle();
        bus_if.in_valid_i = 1'b0;
        tick();
    endtask

    task automatic load_coefs();
        bus_if.in_valid_i = 1'b0;
        bus_if.Set_data_i = 1'b1;
        // Anything that would have surfaced after the next edge is flushed.
        while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
        res_num = 0;
        tick();
        bus_if.Set_data_i = 1'b0;
        for (int t = 0; t < NUM_PARTICLE_TYPE; t++)
            bus_if.self_energy_vec_i[(NUM_PARTICLE_TYPE-1-t)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(self_m[t]);
        for (int a = 0; a < NUM_PARTICLE_TYPE; a++)
            for (int b = 0; b < NUM_PARTICLE_TYPE; b++)
                bus_if.interact_matrix_i[(NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE-1-(a*NUM_PARTICLE_TYPE+b))*DATA_WIDTH +: DATA_WIDTH]
                    = DATA_WIDTH'(inter_m[a][b]);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus_if.in_valid_i = 1'b0;
        while (sb_q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb_q.size() > 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic set_ref_coefs();
        self_m = '{1, 2, 3};
        inter_m[0] = '{10, 4, 1};
        inter_m[1] = '{4, 10, 5};
        inter_m[2] = '{1, 5, 10};
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, int'(bus_if.out_valid_ff_o), 0);
        check({tag, "_done"},      int'(bus_if.done_ff_o), 0);
        check({tag, "_energy"},    int'(bus_if.total_energy_ff_o), 0);
        check({tag, "_tag"},       int'(bus_if.ind_wb_idx_ff_o), 0);
    endtask

    function automatic logic [INDIVIDUAL_LENGTH-1:0] all_type(input int code);
        logic [INDIVIDUAL_LENGTH-1:0] v;
        for (int j = 0; j < LATTICE_LENGTH; j++) v[PARTICLE_LENGTH*j +: PARTICLE_LENGTH] = PARTICLE_LENGTH'(code);
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        bus_if.self_energy_vec_i = '0;
        bus_if.interact_matrix_i = '0;
        bus_if.individual_vec_i  = '0;
        bus_if.in_valid_i        = 1'b0;
        bus_if.Set_data_i        = 1'b0;
        bus_if.ind_idx_i         = 1'b0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Reference coefficients, directed individuals then a random population.
        set_ref_coefs();
        load_coefs();
        check("model_all0", model_energy(all_type(0)), 211);
        check("model_all2", model_energy(all_type(2)), 233);
        send(all_type(0), 1'b1, 1'b1);
        send(all_type(2), 1'b0, 1'b1);
        for (int i = 0; i < POP_SIZE - 2; i++) begin
            if (i == 20) begin
                idle_cycle();
                idle_cycle();
            end
            send(INDIVIDUAL_LENGTH'($urandom), 1'($urandom), 1'b1);
        end
        drain();

        // Population complete: evaluator is idle and must ignore beats.
        for (int i = 0; i < 3; i++) send(INDIVIDUAL_LENGTH'($urandom), 1'($urandom), 1'b0);
        bus_if.in_valid_i = 1'b0;
        repeat (6) tick();

        // New random coefficients, then a reload in the middle of a stream.
        for (int t = 0; t < NUM_PARTICLE_TYPE; t++) begin
            self_m[t] = int'($urandom_range(15, 0));
            for (int b = 0; b < NUM_PARTICLE_TYPE; b++) inter_m[t][b] = int'($urandom_range(15, 0));
        end
        load_coefs();
        for (int i = 0; i < 5; i++) send(INDIVIDUAL_LENGTH'($urandom), 1'($urandom), 1'b1);
        inter_m[1][2] = 15;
        self_m[0]     = 15;
        load_coefs();
        for (int i = 0; i < 12; i++) send(INDIVIDUAL_LENGTH'($urandom), 1'($urandom), 1'b1);
        drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send(INDIVIDUAL_LENGTH'($urandom), 1'b1, 1'b1);
        bus_if.in_valid_i = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        res_num = 0;
        #1;
        check_outputs_zero("midrst");
        tick();
        check_outputs_zero("midrst_next");
        tick();
        rst = 1'b0;
        repeat (8) tick();

        // Recovery after reset.
        set_ref_coefs();
        load_coefs();
        send(all_type(0), 1'b1, 1'b1);
        send(all_type(3), 1'b0, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
